// File: rtl/sample_burst_gen.sv
// Paced sample-strobe burst generator: emits burst_len single-cycle strobes every P clocks.
// Optional sticky overrun flag on ignored starts: define SAMPLE_BURST_OVERRUN_EN.
module sample_burst_gen #(
  parameter int unsigned CNT_WIDTH    = 10,
  parameter int unsigned PERIOD_WIDTH = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    burst_len,
  input  logic [PERIOD_WIDTH-1:0] period,
  input  logic                    stall,
  input  logic                    clear,
  output logic                    sample_strobe,
  output logic [CNT_WIDTH-1:0]    remaining,
  output logic                    busy,
  output logic                    done,
  output logic                    overrun
);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  localparam logic [PERIOD_WIDTH-1:0] PerOne = PERIOD_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0]    CntOne = CNT_WIDTH'(1);

  state_e                  state_q, state_d;
  logic [CNT_WIDTH-1:0]    remaining_q, remaining_d;
  logic [PERIOD_WIDTH-1:0] phase_q, phase_d;
  logic [PERIOD_WIDTH-1:0] period_q, period_d;

  logic [PERIOD_WIDTH-1:0] period_eff;
  logic [PERIOD_WIDTH-1:0] last_phase;
  logic                    at_last_phase;

  // A programmed period of 0 behaves as 1 so every cycle can strobe.
  assign period_eff    = (period == '0) ? PerOne : period;
  assign last_phase    = period_q - PerOne;
  assign at_last_phase = (phase_q == last_phase);

  assign sample_strobe = (state_q == StRun) && at_last_phase && !stall;
  assign remaining     = remaining_q;
  assign busy          = (state_q == StRun);
  assign done          = (state_q == StDone);

  always_comb begin
    state_d     = state_q;
    remaining_d = remaining_q;
    phase_d     = phase_q;
    period_d    = period_q;

    if (clear) begin
      state_d     = StIdle;
      remaining_d = '0;
      phase_d     = '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start) begin
            period_d = period_eff;
            if (burst_len != '0) begin
              state_d     = StRun;
              remaining_d = burst_len;
              phase_d     = period_eff - PerOne;
            end else begin
              state_d = StDone;
            end
          end
        end
        StRun: begin
          if (!stall) begin
            if (at_last_phase) begin
              phase_d = '0;
              if (remaining_q != '0) begin
                remaining_d = remaining_q - CntOne;
              end
              if (remaining_q <= CntOne) begin
                state_d = StDone;
              end
            end else begin
              phase_d = phase_q + PerOne;
            end
          end
        end
        StDone: begin
          state_d     = StIdle;
          remaining_d = '0;
        end
        default: begin
          state_d     = StIdle;
          remaining_d = '0;
          phase_d     = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      remaining_q <= '0;
      phase_q     <= '0;
      period_q    <= PerOne;
    end else begin
      state_q     <= state_d;
      remaining_q <= remaining_d;
      phase_q     <= phase_d;
      period_q    <= period_d;
    end
  end

`ifdef SAMPLE_BURST_OVERRUN_EN
  logic overrun_q, overrun_d;

  // Sticky until clear or rst; clear wins over a coincident ignored start.
  always_comb begin
    overrun_d = overrun_q;
    if (clear) begin
      overrun_d = 1'b0;
    end else if (start && (state_q != StIdle)) begin
      overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      overrun_q <= 1'b0;
    end else begin
      overrun_q <= overrun_d;
    end
  end

  assign overrun = overrun_q;
`else
  assign overrun = 1'b0;
`endif

endmodule

// File: doc/sample_burst_gen.md
Name: sample_burst_gen

Overview:
- Producer-side counterpart of the sample-count path: emits a programmed burst of single-cycle sample strobes at a fixed pacing interval.
- Its strobes feed a downstream sample counter's count-enable and the sample datapath.
- Counts the burst down, honours a downstream stall, and signals completion with a one-cycle done pulse.

Parameters:
- CNT_WIDTH, 10, width of burst length and remaining-count (max burst 2^CNT_WIDTH-1; default covers 1000).
- PERIOD_WIDTH, 8, width of the strobe interval field.

Ports:
- clk  input  1  system clock, all state on rising edge.
- rst  input  1  synchronous active-high reset.
- start  input  1  request a burst; sampled only in IDLE.
- burst_len  input  CNT_WIDTH  number of strobes; latched on accepted start.
- period  input  PERIOD_WIDTH  clocks between strobes; latched on accepted start; 0 treated as 1.
- stall  input  1  downstream not ready; freezes pacing.
- clear  input  1  synchronous abort; returns to IDLE.
- sample_strobe  output  1  one-cycle sample pulse.
- remaining  output  CNT_WIDTH  strobes still to emit.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse at normal burst completion.
- overrun  output  1  see Optional Feature.

Behaviour:
- Reset (rst sampled high): state IDLE; remaining=0, phase=0, latched period=1; sample_strobe=0, busy=0, done=0, overrun=0. rst overrides all other inputs.
- States: IDLE, RUN, DONE. busy = (state==RUN). done = (state==DONE).
- Effective period P = max(period,1), latched at start.
- IDLE + start + !clear + burst_len!=0: next state RUN, remaining<=burst_len, phase<=P-1.
- IDLE + start + !clear + burst_len==0: next state DONE, no strobes, busy stays 0.
- start in RUN or DONE: ignored; latched values unchanged.
- sample_strobe = (state==RUN) && (phase==P-1) && !stall. It is combinational on stall and has no other combinational path.
- First strobe is 1 cycle after start if stall is low.
- In RUN with stall high: phase and remaining hold; no strobe.
- In RUN with stall low:
  - On a strobe: phase<=0 and remaining<=remaining-1. If remaining was 1, next state DONE.
  - Otherwise: phase<=phase+1.
- Strobe spacing is exactly P unstalled cycles.
- DONE lasts exactly one cycle, then IDLE. remaining is 0 in DONE.
- clear (any state, rst low): next state IDLE, remaining<=0, phase<=0, no done pulse. clear beats a simultaneous start. A strobe already shown in the same cycle as clear counts externally, but the abort still applies.
- Arithmetic: remaining never wraps; the decrement happens only when remaining>=1. phase fits in PERIOD_WIDTH.

Optional Feature:
- Macro: SAMPLE_BURST_OVERRUN_EN.
- Defined:
  - overrun is a sticky flag, set the cycle after start is sampled high while state is RUN or DONE.
  - Cleared only by rst or clear. If clear and a set condition coincide, clear wins.
  - The ignored start has no other effect.
- Undefined: overrun is tied to 0 and no flag register exists. All other behaviour is identical.

Test Plan:
- Basic burst: burst_len=3, period=4, start at cycle 0, stall=0 -> strobes at cycles 1,5,9; remaining 3,2,1 in those cycles; busy cycles 1-9; done at cycle 10 only; IDLE at 11.
- Back-to-back and zero period: burst_len=4, period=0 then period=1 -> strobes in cycles 1-4, done at cycle 5, for both runs.
- Zero length: burst_len=0, start at cycle 0 -> done at cycle 1; no strobe; busy never high; remaining=0.
- Stall: burst_len=2, period=3, stall high in cycles 1-2 -> strobes at cycles 3 and 6, done at cycle 7; no strobe while stall=1.
- Abort and reset: burst_len=5, period=2, clear at cycle 4 -> IDLE at cycle 5, remaining=0, no done. Repeat with rst at cycle 4 -> all outputs 0 at cycle 5. clear+start together in IDLE -> stays IDLE.
- Overrun (macro defined): start again at cycle 3 of a burst_len=3, period=4 run -> overrun=1 from cycle 4, burst unaffected (done at 10), overrun stays 1 until clear. With macro undefined, overrun stays 0 throughout.
